// File: rtl/warp_fetch_queue_pkg.sv
// Shared definitions for the warp fetch queue.
// Also carries the shared header defines (parcel width, fetch-word parcels,
// decode-window parcels) so every file of the block sees the same values.
// Contents:
//   PARCEL_W, FETCH_PARCELS, WINDOW_PARCELS  geometry constants
//   clip_count()                             min(n, WINDOW_PARCELS) as a 3-bit count

`ifndef WARP_DEFS_VH
`define WARP_DEFS_VH
`define WARP_PARCEL_W 16
`define WARP_FETCH_PARCELS 4
`define WARP_WINDOW_PARCELS 4
`endif

package warp_fetch_queue_pkg;

  localparam int PARCEL_W       = `WARP_PARCEL_W;
  localparam int FETCH_PARCELS  = `WARP_FETCH_PARCELS;
  localparam int WINDOW_PARCELS = `WARP_WINDOW_PARCELS;

  function automatic logic [2:0] clip_count(input int unsigned n);
    return (n > WINDOW_PARCELS) ? 3'(WINDOW_PARCELS) : 3'(n);
  endfunction

endpackage

// File: rtl/warp_fetch_queue_window.sv
// Combinational 4-parcel gather from a circular parcel store.
// Parcels rd_ptr..rd_ptr+3 (modulo DEPTH) are placed at window[15:0] upward;
// slots at or beyond min(count,4) are forced to zero.
// Ports:
//   mem_flat      in   DEPTH*16  parcel store, parcel i in [16i+15:16i]
//   rd_ptr        in   log2(DEPTH)  first parcel to present
//   count         in   log2(DEPTH)+1  valid parcels from rd_ptr
//   window        out  64        gathered parcels
//   window_count  out  3         min(count,4)

module warp_fetch_queue_window
  import warp_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic [DEPTH*PARCEL_W-1:0]       mem_flat,
  input  logic [$clog2(DEPTH)-1:0]        rd_ptr,
  input  logic [$clog2(DEPTH):0]          count,
  output logic [WINDOW_PARCELS*PARCEL_W-1:0] window,
  output logic [2:0]                      window_count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  always_comb begin
    window_count = clip_count(32'(count));
    window       = '0;
    idx          = '0;
    for (int k = 0; k < WINDOW_PARCELS; k++) begin
      // Pointer arithmetic truncates to PW bits, giving the wraparound.
      idx = rd_ptr + PW'(k);
      if (3'(k) < window_count)
        window[k*PARCEL_W +: PARCEL_W] = mem_flat[idx*PARCEL_W +: PARCEL_W];
    end
  end

endmodule

// File: rtl/warp_fetch_queue.sv
// Parcel-granular instruction queue in front of decode.
// Accepts aligned 64-bit fetch words, stores them as 16-bit parcels, presents a
// 4-parcel window from the head, retires consumed parcels, discards on redirect.
// Optional feature macro: WARP_FETCH_QUEUE_BYPASS_EN -- when the queue is empty,
// an accepted word is shown on the window outputs in the same cycle.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_fetch_valid/o_fetch_ready/i_fetch_data   fetch word handshake
//   i_flush, i_flush_pc     redirect (wins over push and consume)
//   o_buffer, o_count, o_pc decode window, valid parcel count, PC of parcel 0
//   i_consume               parcels retired this cycle (<= o_count)

module warp_fetch_queue
  import warp_fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 16,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_fetch_valid,
  output logic        o_fetch_ready,
  input  logic [63:0] i_fetch_data,
  input  logic        i_flush,
  input  logic [63:0] i_flush_pc,
  output logic [63:0] o_buffer,
  output logic [2:0]  o_count,
  output logic [63:0] o_pc,
  input  logic [2:0]  i_consume
);

  localparam int PW = $clog2(DEPTH);

  logic [PARCEL_W-1:0]       mem [DEPTH];
  logic [DEPTH*PARCEL_W-1:0] mem_flat;
  logic [PW-1:0]             rd_ptr;
  logic [PW-1:0]             wr_ptr;
  logic [PW:0]               count;
  logic [63:0]               pc;
  logic [1:0]                drop;
  logic                      push;
  logic [2:0]                push_n;
  logic [63:0]               q_window;
  logic [2:0]                q_count;
  logic [63:0]               byp_window;
  logic [2:0]                byp_count;
  logic                      bypass;

  always_comb begin
    mem_flat = '0;
    for (int k = 0; k < DEPTH; k++)
      mem_flat[k*PARCEL_W +: PARCEL_W] = mem[k];
  end

  warp_fetch_queue_window #(.DEPTH(DEPTH)) u_window (
    .mem_flat     (mem_flat),
    .rd_ptr       (rd_ptr),
    .count        (count),
    .window       (q_window),
    .window_count (q_count)
  );

  // Ready looks only at the registered count; a same-cycle consume never helps.
  assign o_fetch_ready = !i_rst && (count <= (PW+1)'(DEPTH - FETCH_PARCELS));
  assign push          = i_fetch_valid && o_fetch_ready && !i_flush;
  assign push_n        = 3'(FETCH_PARCELS) - {1'b0, drop};

`ifdef WARP_FETCH_QUEUE_BYPASS_EN
  // The fetch word itself is a 4-entry store; starting the gather at drop
  // with count 4-drop yields exactly the surviving parcels.
  warp_fetch_queue_window #(.DEPTH(FETCH_PARCELS)) u_bypass (
    .mem_flat     (i_fetch_data),
    .rd_ptr       (drop),
    .count        (push_n),
    .window       (byp_window),
    .window_count (byp_count)
  );
  assign bypass = push && (count == '0);
`else
  assign byp_window = '0;
  assign byp_count  = '0;
  assign bypass     = 1'b0;
`endif

  always_comb begin
    o_buffer = q_window;
    o_count  = q_count;
    o_pc     = pc;
    if (i_rst) begin
      o_buffer = '0;
      o_count  = '0;
      o_pc     = RESET_PC;
    end else if (bypass) begin
      o_buffer = byp_window;
      o_count  = byp_count;
    end
  end

  // A bypassed word is still written in full and the consume simply advances
  // rd_ptr over it; only the unconsumed remainder stays counted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      pc     <= RESET_PC;
      drop   <= '0;
    end else if (i_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      pc     <= i_flush_pc & ~64'h1;
      drop   <= i_flush_pc[2:1];
    end else begin
      rd_ptr <= rd_ptr + PW'(i_consume);
      pc     <= pc + {60'd0, i_consume, 1'b0};
      count  <= count + (push ? (PW+1)'(push_n) : '0) - (PW+1)'(i_consume);
      if (push) begin
        wr_ptr <= wr_ptr + PW'(push_n);
        drop   <= '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      for (int k = 0; k < FETCH_PARCELS; k++)
        if (2'(k) >= drop)
          mem[wr_ptr + PW'(k) - PW'(drop)] <= i_fetch_data[k*PARCEL_W +: PARCEL_W];
    end
  end

  assert property (@(posedge i_clk) disable iff (i_rst || i_flush) (i_consume <= o_count))
    else $error("warp_fetch_queue: i_consume exceeds o_count");

endmodule

// File: tb/tb_warp_fetch_queue.sv
module tb_warp_fetch_queue;

  localparam int          DEPTH  = 16;
  localparam logic [63:0] RST_PC = 64'h8000_0000;
`ifdef WARP_FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fv = 1'b0;
  logic        fr;
  logic [63:0] fd = '0;
  logic        fl = 1'b0;
  logic [63:0] fpc = '0;
  logic [63:0] buf_o;
  logic [2:0]  cnt_o;
  logic [63:0] pc_o;
  logic [2:0]  cons = '0;

  always #5 clk = ~clk;

  warp_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_fetch_valid (fv),
    .o_fetch_ready (fr),
    .i_fetch_data  (fd),
    .i_flush       (fl),
    .i_flush_pc    (fpc),
    .o_buffer      (buf_o),
    .o_count       (cnt_o),
    .o_pc          (pc_o),
    .i_consume     (cons)
  );

  typedef struct {
    logic [63:0] b;
    logic [2:0]  c;
    logic [63:0] p;
    logic        r;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] pq[$];      // reference queue of parcels, head first
  logic [63:0] m_pc;
  logic [1:0]  m_drop;
  int          n_total = 0;
  int          n_pass  = 0;

  // One cycle of stimulus: drive inputs, predict this cycle's outputs, advance the model.
  task automatic drive(input bit r, input bit v, input logic [63:0] d,
                       input bit f, input logic [63:0] p, input int cons_req);
    exp_t        e;
    logic [15:0] vis[$];
    bit          rdy, psh;
    int          ecnt, nc;
    @(negedge clk);
    rst = r; fv = v; fd = d; fl = f; fpc = p;
    rdy = 1'b0; psh = 1'b0;
    if (r) begin
      e.b = '0; e.c = '0; e.p = RST_PC; e.r = 1'b0; ecnt = 0;
    end else begin
      rdy = (DEPTH - pq.size()) >= 4;
      psh = v && rdy && !f;
      vis.delete();
      if (BYP && psh && pq.size() == 0) begin
        for (int k = int'(m_drop); k < 4; k++) vis.push_back(d[16*k +: 16]);
      end else begin
        vis = pq;
      end
      ecnt = (vis.size() > 4) ? 4 : vis.size();
      e.b = '0;
      for (int i = 0; i < ecnt; i++) e.b[16*i +: 16] = vis[i];
      e.c = 3'(ecnt); e.p = m_pc; e.r = rdy;
    end
    nc = (cons_req < 0) ? int'($urandom_range(ecnt, 0)) : ((cons_req > ecnt) ? ecnt : cons_req);
    cons = 3'(nc);
    exp_q.push_back(e);
    if (r) begin
      pq.delete(); m_pc = RST_PC; m_drop = 2'd0;
    end else if (f) begin
      pq.delete(); m_pc = p & ~64'h1; m_drop = p[2:1];
    end else begin
      if (psh) begin
        for (int k = int'(m_drop); k < 4; k++) pq.push_back(d[16*k +: 16]);
        m_drop = 2'd0;
      end
      for (int i = 0; i < nc; i++) void'(pq.pop_front());
      m_pc = m_pc + 64'(2 * nc);
    end
  endtask

  task automatic idle(input int c);
    drive(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, c);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  // Monitor: every driven cycle has one predicted response waiting in exp_q.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_total++;
        if (buf_o === e.b && cnt_o === e.c && pc_o === e.p && fr === e.r) n_pass++;
        else $display("FAIL window t=%0t: got buf=%h cnt=%0d pc=%h rdy=%b expected buf=%h cnt=%0d pc=%h rdy=%b",
                      $time, buf_o, cnt_o, pc_o, fr, e.b, e.c, e.p, e.r);
      end
    end
  end

  initial begin
    m_pc = RST_PC; m_drop = 2'd0;

    // Reset held two cycles
    drive(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 0);
    #3 check("rst_ready", 64'(fr), 64'h0);
    check("rst_count", 64'(cnt_o), 64'h0);
    check("rst_pc", pc_o, RST_PC);
    drive(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 0);
    idle(0);
    #3 check("post_rst_ready", 64'(fr), 64'h1);
    check("post_rst_pc", pc_o, RST_PC);

    // Push one word, then retire three parcels
    drive(1'b0, 1'b1, 64'h4444_3333_2222_1111, 1'b0, 64'h0, 0);
    idle(3);
    #3 check("push_buf", buf_o, 64'h4444_3333_2222_1111);
    check("push_count", 64'(cnt_o), 64'h4);
    idle(0);
    #3 check("consume_buf", buf_o, 64'h0000_0000_0000_4444);
    check("consume_count", 64'(cnt_o), 64'h1);
    check("consume_pc", pc_o, RST_PC + 64'd6);

    // Redirect into the middle of a word
    drive(1'b0, 1'b0, 64'h0, 1'b1, 64'h1006, 0);
    drive(1'b0, 1'b1, 64'hDDDD_CCCC_BBBB_AAAA, 1'b0, 64'h0, 0);
    idle(0);
    #3 check("flush_buf", buf_o, 64'h0000_0000_0000_DDDD);
    check("flush_count", 64'(cnt_o), 64'h1);
    check("flush_pc", pc_o, 64'h1006);

    // Fill to capacity, then free one word's worth
    drive(1'b0, 1'b0, 64'h0, 1'b1, 64'h2000, 0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, {$urandom, $urandom}, 1'b0, 64'h0, 0);
    idle(4);
    #3 check("full_ready", 64'(fr), 64'h0);
    idle(0);
    #3 check("after_consume_ready", 64'(fr), 64'h1);

    // Flush alongside a valid word and a consume
    drive(1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1, 64'h3000, 2);
    idle(0);
    #3 check("flush_drop_count", 64'(cnt_o), 64'h0);
    check("flush_drop_pc", pc_o, 64'h3000);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      bit          r, v, f;
      logic [63:0] d, p;
      r = ($urandom_range(199, 0) == 0);
      f = ($urandom_range(29, 0) == 0);
      v = ($urandom_range(9, 0) < 7);
      d = {$urandom, $urandom};
      p = {$urandom, $urandom};
      drive(r, v, d, f, p, -1);
    end
    idle(0);
    repeat (3) @(negedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d responses left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
